// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game datapath: state encodings, screen size
// and coordinate width used by the physics, collision and render blocks.
package flappy_pkg;
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [2:0] QInitial = 3'b001;
    localparam logic [2:0] QRun     = 3'b010;
    localparam logic [2:0] QHit     = 3'b100;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying pipe gap offsets.
module pipe_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       reset,
    output logic [7:0] o_Value
);
    logic [7:0] r_Lfsr;
    logic       w_Feedback;

    assign w_Feedback = r_Lfsr[7] ^ r_Lfsr[5] ^ r_Lfsr[4] ^ r_Lfsr[3];
    assign o_Value    = r_Lfsr;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_Lfsr <= SEED;
        end else begin
            r_Lfsr <= {r_Lfsr[6:0], w_Feedback};
        end
    end
endmodule

// File: rtl/pipe_collision.sv
// Scrolling pipe pair, bird/pipe collision detection and score keeping.
// Optional build macro FLOOR_COLLIDE_EN makes touching the floor end the round.
module pipe_collision
    import flappy_pkg::*;
#(
    parameter int         PIPE_WIDTH   = 40,
    parameter int         GAP_HEIGHT   = 120,
    parameter int         SCROLL_SPEED = 2,
    parameter int         SCREEN_W     = DEF_SCREEN_W,
    parameter int         SCREEN_H     = DEF_SCREEN_H,
    parameter int         GAP_MIN      = 40,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               FrameTick,
    input  logic [COORD_W-1:0] Bird_X_L,
    input  logic [COORD_W-1:0] Bird_X_R,
    input  logic [COORD_W-1:0] Bird_Y_T,
    input  logic [COORD_W-1:0] Bird_Y_B,
    output logic [COORD_W-1:0] Pipe_X_L,
    output logic [COORD_W-1:0] Pipe_X_R,
    output logic [COORD_W-1:0] Gap_Y_T,
    output logic [COORD_W-1:0] Gap_Y_B,
    output logic [7:0]         Score,
    output logic               Stop,
    output logic               q_Initial,
    output logic               q_Run,
    output logic               q_Hit
);
    localparam coord_t X_L_INIT  = coord_t'(SCREEN_W);
    localparam coord_t X_R_INIT  = coord_t'(SCREEN_W + PIPE_WIDTH);
    localparam coord_t SPEED     = coord_t'(SCROLL_SPEED);
    localparam coord_t GAP_H     = coord_t'(GAP_HEIGHT);
    localparam coord_t GAP_LO    = coord_t'(GAP_MIN);
    localparam coord_t FLOOR_Y   = coord_t'(SCREEN_H);
    localparam coord_t GAP_T_RST = 10'd160;
`ifdef FLOOR_COLLIDE_EN
    localparam logic   FLOOR_EN  = 1'b1;
`else
    localparam logic   FLOOR_EN  = 1'b0;
`endif

    logic [2:0] r_State;
    coord_t     r_PipeXL, r_PipeXR, r_GapT, r_GapB;
    logic [7:0] r_Score;
    logic       r_Scored;

    logic [7:0] w_Lfsr;
    coord_t     w_NewGapT, w_NewGapB, w_MovedXL, w_MovedXR;
    logic       w_Overlap, w_OutGap, w_Floor, w_Hit, w_Respawn, w_ScoreNow;

    pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk    (Clk),
        .reset  (reset),
        .o_Value(w_Lfsr)
    );

    assign w_NewGapT  = GAP_LO + {2'b00, w_Lfsr};
    assign w_NewGapB  = w_NewGapT + GAP_H;
    assign w_MovedXL  = r_PipeXL - SPEED;
    assign w_MovedXR  = r_PipeXR - SPEED;
    // Respawn before the subtraction could wrap the 10-bit right edge.
    assign w_Respawn  = (r_PipeXR <= SPEED);
    assign w_ScoreNow = !r_Scored && (w_MovedXR < Bird_X_L);

    assign w_Overlap = (Bird_X_R > r_PipeXL) && (Bird_X_L < r_PipeXR);
    assign w_OutGap  = (Bird_Y_T < r_GapT) || (Bird_Y_B > r_GapB);
    assign w_Floor   = FLOOR_EN && (Bird_Y_B >= FLOOR_Y);
    assign w_Hit     = (w_Overlap && w_OutGap) || w_Floor;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_State  <= QInitial;
            r_PipeXL <= X_L_INIT;
            r_PipeXR <= X_R_INIT;
            r_GapT   <= GAP_T_RST;
            r_GapB   <= GAP_T_RST + GAP_H;
            r_Score  <= 8'd0;
            r_Scored <= 1'b0;
        end else begin
            case (r_State)
                QInitial: begin
                    r_PipeXL <= X_L_INIT;
                    r_PipeXR <= X_R_INIT;
                    if (Start) begin
                        r_State  <= QRun;
                        r_Score  <= 8'd0;
                        r_Scored <= 1'b0;
                        r_GapT   <= w_NewGapT;
                        r_GapB   <= w_NewGapB;
                    end
                end
                QRun: begin
                    // A hit in the same cycle as a frame tick freezes the pipe.
                    if (w_Hit) begin
                        r_State <= QHit;
                    end else if (FrameTick) begin
                        if (w_Respawn) begin
                            r_PipeXL <= X_L_INIT;
                            r_PipeXR <= X_R_INIT;
                            r_GapT   <= w_NewGapT;
                            r_GapB   <= w_NewGapB;
                            r_Scored <= 1'b0;
                        end else begin
                            r_PipeXL <= w_MovedXL;
                            r_PipeXR <= w_MovedXR;
                            if (w_ScoreNow) begin
                                r_Score  <= (r_Score == 8'hFF) ? r_Score : r_Score + 8'd1;
                                r_Scored <= 1'b1;
                            end
                        end
                    end
                end
                QHit: begin
                    if (Ack) begin
                        r_State  <= QInitial;
                        r_PipeXL <= X_L_INIT;
                        r_PipeXR <= X_R_INIT;
                    end
                end
                default: begin
                    r_State <= QInitial;
                end
            endcase
        end
    end

    assign Pipe_X_L  = r_PipeXL;
    assign Pipe_X_R  = r_PipeXR;
    assign Gap_Y_T   = r_GapT;
    assign Gap_Y_B   = r_GapB;
    assign Score     = r_Score;
    assign Stop      = (r_State == QHit);
    assign q_Initial = (r_State == QInitial);
    assign q_Run     = (r_State == QRun);
    assign q_Hit     = (r_State == QHit);
endmodule

// File: tb/tb_pipe_collision.sv
// Directed bench for pipe_collision: pipe scroll, respawn, scoring, hits, floor, reset.
module tb_pipe_collision;
    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0, Ack = 1'b0, FrameTick = 1'b0;
    logic [9:0] BXL = 10'd300, BXR = 10'd320, BYT = 10'd220, BYB = 10'd240;
    logic [9:0] PXL, PXR, GYT, GYB;
    logic [7:0] Score;
    logic       Stop, qI, qR, qH;

    logic       fStart = 1'b0, fTick = 1'b0;
    logic [9:0] fPXL, fPXR, fGYT, fGYB;
    logic [7:0] fScore;
    logic       fStop, fqI, fqR, fqH;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] m_lfsr;
    logic [7:0] tick_lfsr;
    int exp_gt, exp_xl, exp_xr;
    int tries;

    always #5 Clk = ~Clk;

    pipe_collision u_dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .FrameTick(FrameTick),
        .Bird_X_L(BXL), .Bird_X_R(BXR), .Bird_Y_T(BYT), .Bird_Y_B(BYB),
        .Pipe_X_L(PXL), .Pipe_X_R(PXR), .Gap_Y_T(GYT), .Gap_Y_B(GYB),
        .Score(Score), .Stop(Stop), .q_Initial(qI), .q_Run(qR), .q_Hit(qH)
    );

    // Fast-scrolling instance so the score can reach saturation in few cycles.
    pipe_collision #(.SCROLL_SPEED(40)) u_fast (
        .Clk(Clk), .reset(reset), .Start(fStart), .Ack(1'b0), .FrameTick(fTick),
        .Bird_X_L(10'd700), .Bird_X_R(10'd710), .Bird_Y_T(10'd200), .Bird_Y_B(10'd220),
        .Pipe_X_L(fPXL), .Pipe_X_R(fPXR), .Gap_Y_T(fGYT), .Gap_Y_B(fGYB),
        .Score(fScore), .Stop(fStop), .q_Initial(fqI), .q_Run(fqR), .q_Hit(fqH)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge Clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_tick(input int spacing);
        tick_lfsr = m_lfsr;
        FrameTick = 1'b1;
        step();
        FrameTick = 1'b0;
        repeat (spacing - 1) step();
    endtask

    initial begin
        @(negedge Clk);
        @(negedge Clk);
        check("rst_qI", qI, 1);
        check("rst_pxl", PXL, 640);
        check("rst_pxr", PXR, 680);
        check("rst_gyt", GYT, 160);
        check("rst_gyb", GYB, 280);
        check("rst_score", Score, 0);
        check("rst_stop", Stop, 0);
        reset = 1'b0;

        // Start when the next gap will contain the bird (Y 220..240).
        tries = 0;
        while (!(m_lfsr >= 8'd80 && m_lfsr <= 8'd180) && tries < 300) begin
            step();
            tries++;
        end
        check("lfsr_window", (tries < 300) ? 1 : 0, 1);
        exp_gt = 40 + int'(m_lfsr);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("start_qR", qR, 1);
        check("start_gyt", GYT, exp_gt);
        check("start_gyb", GYB, exp_gt + 120);
        check("start_pxl", PXL, 640);

        exp_xl = 640;
        exp_xr = 680;
        for (int k = 1; k <= 339; k++) begin
            do_tick(4);
            exp_xl -= 2;
            exp_xr -= 2;
            if (k <= 2) check("move_pxl", PXL, exp_xl);
            if (k == 190) check("score_pre", Score, 0);
            if (k == 191) check("score_once", Score, 1);
        end
        check("edge_pxr", PXR, 2);
        check("pass_score", Score, 1);
        check("pass_stop", Stop, 0);

        do_tick(4);
        exp_gt = 40 + int'(tick_lfsr);
        check("respawn_pxl", PXL, 640);
        check("respawn_pxr", PXR, 680);
        check("respawn_gyt", GYT, exp_gt);
        check("respawn_gapw", int'(GYB) - int'(GYT), 120);

        BYT = 10'(exp_gt + 50);
        BYB = 10'(exp_gt + 70);
        for (int k = 0; k < 165; k++) do_tick(1);
        check("approach_pxl", PXL, 310);
        check("approach_pxr", PXR, 350);
        check("approach_stop", Stop, 0);

        // Bird clips the top of the gap on the same cycle as a frame tick.
        BYT = 10'(exp_gt - 1);
        FrameTick = 1'b1;
        step();
        FrameTick = 1'b0;
        check("hit_stop", Stop, 1);
        check("hit_qH", qH, 1);
        check("hit_pxl", PXL, 310);
        do_tick(2);
        check("frozen_pxl", PXL, 310);
        check("frozen_score", Score, 1);
        BYT = 10'(exp_gt + 50);
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        step();
        check("ack_qI", qI, 1);
        check("ack_pxl", PXL, 640);
        check("ack_score", Score, 1);

        Start = 1'b1;
        Ack = 1'b1;
        step();
        Start = 1'b0;
        Ack = 1'b0;
        check("startack_qR", qR, 1);
        check("startack_score", Score, 0);
        do_tick(1);
        check("r2_pxl", PXL, 638);

        BYT = 10'd460;
        BYB = 10'd480;
        step();
`ifdef FLOOR_COLLIDE_EN
        check("floor_stop", Stop, 1);
`else
        check("floor_stop", Stop, 0);
`endif

        reset = 1'b1;
        #1;
        check("async_rst_qI", qI, 1);
        check("async_rst_pxl", PXL, 640);
        check("async_rst_gyt", GYT, 160);
        check("async_rst_stop", Stop, 0);
        @(negedge Clk);
        reset = 1'b0;
        BYT = 10'd220;
        BYB = 10'd240;

        fStart = 1'b1;
        step();
        fStart = 1'b0;
        check("fast_qR", fqR, 1);
        fTick = 1'b1;
        repeat (4318) step();
        check("sat_pre", fScore, 254);
        step();
        check("sat_255", fScore, 255);
        repeat (200) step();
        fTick = 1'b0;
        check("sat_hold", fScore, 255);
        check("fast_stop", fStop, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_collision.md
# pipe_collision

Obstacle and collision stage that sits directly downstream of the bird flight-physics block. It owns one scrolling pipe pair with a pseudo-random gap and compares the bird bounding box against the pipes and the floor every cycle. It raises `Stop` back to the physics block on a hit and keeps the player score. The VGA renderer consumes its pipe coordinates and score.

## Interface

**Parameters**
- `PIPE_WIDTH`, 40: pipe width in pixels.
- `GAP_HEIGHT`, 120: vertical opening in pixels.
- `SCROLL_SPEED`, 2: pixels moved per `FrameTick`.
- `SCREEN_W`, 640: respawn X for the pipe's left edge.
- `SCREEN_H`, 480: floor Y.
- `GAP_MIN`, 40: minimum `Gap_Y_T`.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

**Ports** (reset `reset`, asynchronous, active-high; clock `Clk`)
- `Clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `Start`  in  1  begin round (same pulse as sent to the physics block).
- `Ack`  in  1  acknowledge hit, return to initial.
- `FrameTick`  in  1  one-cycle pulse per video frame.
- `Bird_X_L`, `Bird_X_R`, `Bird_Y_T`, `Bird_Y_B`  in  10 each  bird bounding box from the physics block.
- `Pipe_X_L`, `Pipe_X_R`  out  10 each  pipe horizontal extent.
- `Gap_Y_T`, `Gap_Y_B`  out  10 each  gap vertical extent.
- `Score`  out  8  pipes passed, saturating.
- `Stop`  out  1  level; high while in `QHit`.
- `q_Initial`, `q_Run`, `q_Hit`  out  1 each  one-hot state.

## Operation

**States**
- One-hot: `QInitial` = 3'b001, `QRun` = 3'b010, `QHit` = 3'b100.
- Illegal encodings go to `QInitial`.

**`QInitial`**
- Pipe held at `Pipe_X_L` = `SCREEN_W`, `Pipe_X_R` = `SCREEN_W` + `PIPE_WIDTH`.
- When `Start` is seen:
  - go to `QRun`;
  - `Score` ← 0, `scored` ← 0;
  - `Gap_Y_T` ← `GAP_MIN` + lfsr[7:0], `Gap_Y_B` ← `Gap_Y_T` + `GAP_HEIGHT`.
- `Ack` and `FrameTick` are ignored.

**`QRun`, on `FrameTick`**
- Move: `Pipe_X_L` and `Pipe_X_R` each decrease by `SCROLL_SPEED`.
- Respawn instead of moving if `Pipe_X_R` ≤ `SCROLL_SPEED`. This prevents 10-bit underflow.
  - Pipe returns to its initial X values.
  - New gap is taken from the LFSR.
  - `scored` ← 0.
- Scoring:
  - Condition: `!scored` and the post-move `Pipe_X_R` < `Bird_X_L`.
  - Action: `Score` ← `Score` + 1, saturating at 255; `scored` ← 1.

**`QRun`, every cycle (not only on ticks)**
- `hit` = horizontal overlap AND bird outside the gap.
  - Horizontal overlap: (`Bird_X_R` > `Pipe_X_L`) && (`Bird_X_L` < `Pipe_X_R`).
  - Outside gap: (`Bird_Y_T` < `Gap_Y_T`) || (`Bird_Y_B` > `Gap_Y_B`).
- `hit` causes a transition to `QHit`.
- `Start` is ignored.

**`QHit`**
- Pipe, gap and `Score` are frozen.
- `Ack` returns to `QInitial`.
- `Score` keeps its value until the next `Start`.

**LFSR**
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
- Advances every clock in every state.
- With default parameters the gap spans `Gap_Y_T` 40..295 and `Gap_Y_B` ≤ 415.

**Arithmetic**
- All comparisons are unsigned, 10-bit.
- Pipe X coordinates may exceed 639; they stay ≤ 1023.

## Timing

**Reset values**
- `state` = `QInitial`
- `Pipe_X_L` = 640, `Pipe_X_R` = 680
- `Gap_Y_T` = 160, `Gap_Y_B` = 280
- `Score` = 0, `Stop` = 0, `scored` = 0
- lfsr = `LFSR_SEED`
- A reset at any point, mid-round included, forces all of these immediately.

**Latency**
- `hit` true in cycle N: `Stop` and `q_Hit` are high from edge N+1.
- Pipe and score update on the edge after the `FrameTick` cycle.
- `Start` in cycle N: `q_Run` is high from N+1.

**Simultaneous events**
- Hit and `FrameTick` in the same cycle: hit wins; no move and no score.
- Respawn and score in the same tick: respawn only.
- `Start` and `Ack` together in `QInitial`: `Start` wins.

## Configuration

- `FLOOR_COLLIDE_EN` defined: `hit` additionally includes `Bird_Y_B` ≥ `SCREEN_H`. This lets a bird clamped at the bottom end the round.
- `FLOOR_COLLIDE_EN` undefined: only pipe contact ends the round; the floor is harmless.

## Structure

- Shared package `flappy_pkg`:
  - state encodings `QInitial` / `QRun` / `QHit`;
  - `SCREEN_W` / `SCREEN_H` constants;
  - the coordinate width (10).
- One sub-module, `pipe_lfsr`:
  - inputs: clock, reset, seed parameter;
  - output: 8-bit value;
  - free-running.

## Test plan

- Reset, then `Start`, with the bird box at X 300–320 / Y 220–240, the gap drawn so the bird is inside it, and `FrameTick` every 4 cycles → pipe steps 640→638→636…; `Stop` stays 0.
- Tick until `Pipe_X_R` = 2, then one more tick → `Pipe_X_L`/`Pipe_X_R` = 640/680, new gap with `Gap_Y_B` − `Gap_Y_T` = 120.
- Bird X 300–320, pipe X 310–350, `Bird_Y_T` forced to `Gap_Y_T` − 1 → `Stop` = 1 one cycle later; `Ack` → `q_Initial`; pipe back at 640.
- Bird kept inside the gap while the pipe passes → `Score` 0→1 exactly once when `Pipe_X_R` < 300; after 255 passes `Score` holds at 255.
- `FrameTick` and a hit in the same cycle → pipe X unchanged, `Stop` = 1.
- With `FLOOR_COLLIDE_EN`, `Bird_Y_B` = 480 and no pipe overlap → `Stop` = 1. Without the macro → `Stop` = 0.
